// File: rtl/iter_muldiv_alu.sv
// Multi-cycle ALU: single-cycle ADD/SUB/AND/ORR, radix-2 shift-add MUL/UMULL/SMULL, restoring DIV.
// Define ITER_MULDIV_ALU_SDIV_EN to make op 111 a signed, truncating divide.
module iter_muldiv_alu #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] DIV0_QUOT = {WIDTH{1'b1}}
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result_lo,
    output logic [WIDTH-1:0] o_result_hi,
    output logic [3:0]       o_flags,
    output logic             o_div_by_zero
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_SMULL = 3'b110;
    localparam logic [2:0] OP_DIV   = 3'b111;
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef ITER_MULDIV_ALU_SDIV_EN
    localparam bit SDIV = 1'b1;
`else
    localparam bit SDIV = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e               r_state, w_next;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_op;
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH-1:0]     r_mcand;
    logic                 r_neg_lo, r_neg_hi, r_ovf;
    logic [WIDTH-1:0]     r_lo, r_hi;
    logic [3:0]           r_flags;
    logic                 r_dbz;

    logic                 w_accept, w_last, w_load, w_wide, w_c, w_v, w_dbz, w_qbit;
    logic [WIDTH-1:0]     w_lo, w_hi, w_a_mag, w_b_mag, w_rem_next;
    logic [WIDTH:0]       w_sum, w_madd, w_trial;
    logic [2*WIDTH-1:0]   w_mul_next, w_mul_fin, w_div_next;

    assign w_accept = (r_state == StIdle) && i_start;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_a_mag  = i_a[WIDTH-1] ? -i_a : i_a;
    assign w_b_mag  = i_b[WIDTH-1] ? -i_b : i_b;

    // Multiplier sits in the low half and shifts out LSB-first while partial sums enter the top.
    assign w_madd     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_prod[0] ? r_mcand : '0)};
    assign w_mul_next = {w_madd, r_prod[WIDTH-1:1]};
    assign w_mul_fin  = r_neg_lo ? -w_mul_next : w_mul_next;

    // Divide reuses r_prod: remainder in the high half, dividend shifting into quotient below.
    assign w_trial    = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]} - {1'b0, r_mcand};
    assign w_qbit     = ~w_trial[WIDTH];
    assign w_rem_next = w_qbit ? w_trial[WIDTH-1:0] : {r_prod[2*WIDTH-2:WIDTH], r_prod[WIDTH-1]};
    assign w_div_next = {w_rem_next, r_prod[WIDTH-2:0], w_qbit};

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_lo   = '0;
        w_hi   = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        w_dbz  = 1'b0;
        w_wide = 1'b0;
        w_sum  = '0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    if (!i_op[2]) begin
                        w_next = StDone;
                        w_load = 1'b1;
                        unique case (i_op[1:0])
                            2'b00: begin
                                w_sum = {1'b0, i_a} + {1'b0, i_b};
                                w_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                                        (w_sum[WIDTH-1] != i_a[WIDTH-1]);
                            end
                            2'b01: begin
                                w_sum = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
                                w_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                                        (w_sum[WIDTH-1] != i_a[WIDTH-1]);
                            end
                            2'b10:   w_sum = {1'b0, i_a & i_b};
                            default: w_sum = {1'b0, i_a | i_b};
                        endcase
                        w_lo = w_sum[WIDTH-1:0];
                        w_c  = w_sum[WIDTH] && !i_op[1];
                    end else if (i_op == OP_DIV) begin
                        if (i_b == '0) begin
                            w_next = StDone;
                            w_load = 1'b1;
                            w_lo   = DIV0_QUOT;
                            w_hi   = i_a;
                            w_dbz  = 1'b1;
                        end else begin
                            w_next = StDiv;
                        end
                    end else begin
                        w_next = StMul;
                    end
                end
            end
            StMul: begin
                if (w_last) begin
                    w_next = StDone;
                    w_load = 1'b1;
                    w_wide = (r_op != OP_MUL);
                    w_lo   = w_mul_fin[WIDTH-1:0];
                    w_hi   = w_wide ? w_mul_fin[2*WIDTH-1:WIDTH] : '0;
                end
            end
            StDiv: begin
                if (w_last) begin
                    w_next = StDone;
                    w_load = 1'b1;
                    w_lo   = r_neg_lo ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0];
                    w_hi   = r_neg_hi ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH];
                    w_v    = r_ovf;
                end
            end
            default: w_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_op     <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_ovf    <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_flags  <= '0;
            r_dbz    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt    <= '0;
                r_op     <= i_op;
                r_mcand  <= i_a;
                r_prod   <= {{WIDTH{1'b0}}, i_b};
                r_neg_lo <= 1'b0;
                r_neg_hi <= 1'b0;
                r_ovf    <= 1'b0;
                if (i_op == OP_SMULL) begin
                    r_mcand  <= w_a_mag;
                    r_prod   <= {{WIDTH{1'b0}}, w_b_mag};
                    r_neg_lo <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
                end else if (i_op == OP_DIV) begin
                    r_mcand  <= SDIV ? w_b_mag : i_b;
                    r_prod   <= {{WIDTH{1'b0}}, (SDIV ? w_a_mag : i_a)};
                    r_neg_lo <= SDIV && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                    r_neg_hi <= SDIV && i_a[WIDTH-1];
                    r_ovf    <= SDIV && (i_a == SMIN) && (&i_b);
                end
            end else if (r_state == StMul) begin
                r_prod <= w_mul_next;
                r_cnt  <= r_cnt + CW'(1);
            end else if (r_state == StDiv) begin
                r_prod <= w_div_next;
                r_cnt  <= r_cnt + CW'(1);
            end
            if (w_load) begin
                r_lo    <= w_lo;
                r_hi    <= w_hi;
                r_flags <= {(w_wide ? w_hi[WIDTH-1] : w_lo[WIDTH-1]),
                            (w_wide ? ({w_hi, w_lo} == '0) : (w_lo == '0)), w_c, w_v};
                r_dbz   <= w_dbz;
            end
        end
    end

    assign o_busy        = (r_state != StIdle);
    assign o_done        = (r_state == StDone);
    assign o_result_lo   = r_lo;
    assign o_result_hi   = r_hi;
    assign o_flags       = r_flags;
    assign o_div_by_zero = r_dbz;
endmodule

// File: tb/tb_iter_muldiv_alu.sv
// Self-checking bench for iter_muldiv_alu (WIDTH=32): directed cases plus random ops vs. a model.
module tb_iter_muldiv_alu;
    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  flags;
        logic        dbz;
        logic [7:0]  lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   op_i;
    logic [W-1:0] a_i, b_i;
    logic         busy, done, dbz;
    logic [W-1:0] lo, hi;
    logic [3:0]   flags;
    int           n_checks = 0;
    int           n_fail = 0;

    iter_muldiv_alu #(.WIDTH(W)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op_i), .i_a(a_i), .i_b(b_i),
        .o_busy(busy), .o_done(done), .o_result_lo(lo), .o_result_hi(hi), .o_flags(flags),
        .o_div_by_zero(dbz)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] l, input logic [31:0] h, input logic [3:0] f,
                                input logic z, input int lat);
        exp_t e;
        e.lo = l; e.hi = h; e.flags = f; e.dbz = z; e.lat = 8'(lat);
        return e;
    endfunction

    // Reference: plain 64-bit arithmetic, no notion of iterations.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb, sr;
        logic [63:0] p;
        logic wide;
        e = '0; wide = 1'b0; e.lat = 8'd33;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin
                p = {32'b0, a} + {32'b0, b}; e.lo = p[31:0]; e.flags[1] = p[32];
                sr = sa + sb; e.flags[0] = (sr > SMAX) || (sr < SMIN); e.lat = 1;
            end
            3'd1: begin
                e.lo = a - b; e.flags[1] = (a >= b);
                sr = sa - sb; e.flags[0] = (sr > SMAX) || (sr < SMIN); e.lat = 1;
            end
            3'd2: begin e.lo = a & b; e.lat = 1; end
            3'd3: begin e.lo = a | b; e.lat = 1; end
            3'd4: begin p = {32'b0, a} * {32'b0, b}; e.lo = p[31:0]; end
            3'd5: begin p = {32'b0, a} * {32'b0, b}; e.lo = p[31:0]; e.hi = p[63:32]; wide = 1; end
            3'd6: begin p = 64'(sa * sb); e.lo = p[31:0]; e.hi = p[63:32]; wide = 1; end
            default: begin
                if (b == 0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = a; e.dbz = 1'b1; e.lat = 1;
                end else begin
`ifdef ITER_MULDIV_ALU_SDIV_EN
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        e.lo = 32'h8000_0000; e.hi = 0; e.flags[0] = 1'b1;
                    end else begin
                        e.lo = 32'(sa / sb); e.hi = 32'(sa % sb);
                    end
`else
                    e.lo = a / b; e.hi = a % b;
`endif
                end
            end
        endcase
        e.flags[3] = wide ? e.hi[31] : e.lo[31];
        e.flags[2] = wide ? ({e.hi, e.lo} == 64'd0) : (e.lo == 32'd0);
        return e;
    endfunction

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e);
        int lat;
        logic early_idle;
        @(negedge clk);
        start = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk); #1;
        start = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
        lat = 0; early_idle = 1'b0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            if (done) lat = c;
            else begin
                if (!busy) early_idle = 1'b1;
                @(posedge clk); #1;
            end
        end
        check_eq({tag, "/latency"}, 64'(lat), 64'(e.lat));
        check_eq({tag, "/busy_wait"}, early_idle, 0);
        check_eq({tag, "/busy_done"}, busy, 1);
        check_eq({tag, "/lo"}, lo, e.lo);
        check_eq({tag, "/hi"}, hi, e.hi);
        check_eq({tag, "/flags"}, flags, e.flags);
        check_eq({tag, "/dbz"}, dbz, e.dbz);
        @(posedge clk); #1;
        check_eq({tag, "/done_pulse"}, done, 0);
        check_eq({tag, "/idle"}, busy, 0);
        check_eq({tag, "/lo_hold"}, lo, e.lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic seen_done;
        logic [2:0] rop;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; op_i = '0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst/busy", busy, 0);
        check_eq("rst/done", done, 0);
        check_eq("rst/outs", {lo, hi, flags, dbz}, 0);
        reset = 1'b0;

        do_op("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'h1, mk(32'h8000_0000, 0, 4'b1001, 0, 1));
        do_op("sub_borrow", 3'd1, 32'd5, 32'd7, mk(32'hFFFF_FFFE, 0, 4'b1000, 0, 1));
        do_op("sub_carry", 3'd1, 32'd7, 32'd5, mk(32'h2, 0, 4'b0010, 0, 1));
        do_op("umull_max", 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              mk(32'h1, 32'hFFFF_FFFE, 4'b1000, 0, 33));
        do_op("smull_neg", 3'd6, 32'hFFFF_FFFE, 32'd3, mk(32'hFFFF_FFFA, 32'hFFFF_FFFF, 4'b1000, 0, 33));
        do_op("mul_zero", 3'd4, 32'd0, 32'd5, mk(0, 0, 4'b0100, 0, 33));
        do_op("div_100_7", 3'd7, 32'd100, 32'd7, mk(32'd14, 32'd2, 4'b0000, 0, 33));
        do_op("div_by_0", 3'd7, 32'd100, 32'd0, mk(32'hFFFF_FFFF, 32'd100, 4'b1000, 1, 1));
`ifdef ITER_MULDIV_ALU_SDIV_EN
        do_op("sdiv_neg", 3'd7, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b1000, 0, 33));
        do_op("sdiv_ovf", 3'd7, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 0, 4'b1001, 0, 33));
`else
        do_op("udiv_big", 3'd7, 32'hFFFF_FFF9, 32'd2, mk(32'h7FFF_FFFC, 32'h1, 4'b0000, 0, 33));
`endif

        // Abort an in-flight UMULL; a stray start while busy must be ignored.
        @(negedge clk);
        start = 1'b1; op_i = 3'd5; a_i = 32'h1234_5678; b_i = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        seen_done = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            start = (c == 5);
            if (c == 5) op_i = 3'd0;
            if (c == 10) reset = 1'b1;
            if (done) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0; reset = 1'b0;
        check_eq("abort/done_before", seen_done, 0);
        check_eq("abort/busy", busy, 0);
        check_eq("abort/done", done, 0);
        check_eq("abort/outs", {lo, hi, flags, dbz}, 0);
        for (int c = 0; c < 40; c++) begin
            if (done) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        check_eq("abort/no_done", seen_done, 0);
        do_op("after_abort", 3'd0, 32'd20, 32'd22, model(3'd0, 32'd20, 32'd22));

        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            do_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
